// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: passes non-memory ops through the M/W latch in one cycle and
// holds the pipeline while a lw/sw waits on a bounded-latency memory handshake.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_in,
  input  logic [31:0] o_in,
  input  logic [31:0] b_in,
  input  logic        valid_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir_out,
  output logic [31:0] o_out,
  output logic [31:0] d_out,
  output logic        valid_out,
  output logic        mem_timeout
);

  localparam logic [4:0] OpLw = 5'b01000;
  localparam logic [4:0] OpSw = 5'b00111;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] hold_o_q, hold_o_d;
  logic [31:0] hold_b_q, hold_b_d;
  logic [31:0] ir_out_q, ir_out_d;
  logic [31:0] o_out_q, o_out_d;
  logic [31:0] d_out_q, d_out_d;
  logic        valid_out_q, valid_out_d;
  logic        timeout_q, timeout_d;

  logic is_mem_in;
  logic hold_is_lw;
  logic hold_is_sw;
  logic timer_last;

  assign is_mem_in  = valid_in && ((ir_in[31:27] == OpLw) || (ir_in[31:27] == OpSw));
  assign hold_is_lw = (hold_ir_q[31:27] == OpLw);
  assign hold_is_sw = (hold_ir_q[31:27] == OpSw);
  assign timer_last = (timer_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= 8'd0;
      hold_ir_q   <= 32'd0;
      hold_o_q    <= 32'd0;
      hold_b_q    <= 32'd0;
      ir_out_q    <= 32'd0;
      o_out_q     <= 32'd0;
      d_out_q     <= 32'd0;
      valid_out_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      hold_ir_q   <= hold_ir_d;
      hold_o_q    <= hold_o_d;
      hold_b_q    <= hold_b_d;
      ir_out_q    <= ir_out_d;
      o_out_q     <= o_out_d;
      d_out_q     <= d_out_d;
      valid_out_q <= valid_out_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    hold_ir_d   = hold_ir_q;
    hold_o_d    = hold_o_q;
    hold_b_d    = hold_b_q;
    ir_out_d    = 32'd0;
    o_out_d     = 32'd0;
    d_out_d     = 32'd0;
    valid_out_d = 1'b0;
    timeout_d   = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem_in) begin
          hold_ir_d = ir_in;
          hold_o_d  = o_in;
          hold_b_d  = b_in;
          timer_d   = 8'd0;
          state_d   = StBusy;
        end else if (valid_in) begin
          ir_out_d    = ir_in;
          o_out_d     = o_in;
          valid_out_d = 1'b1;
        end
      end
      StBusy: begin
        // An ack on the last allowed cycle still completes the access.
        if (mem_ack) begin
          ir_out_d    = hold_ir_q;
          o_out_d     = hold_o_q;
          d_out_d     = hold_is_lw ? mem_rdata : 32'd0;
          valid_out_d = 1'b1;
          state_d     = StIdle;
        end else if (timer_last) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 12'd0;
    mem_wdata = 32'd0;
    if (!reset) begin
      if (state_q == StIdle) begin
        stall = is_mem_in;
      end else begin
        stall     = !(mem_ack || timer_last);
        mem_req   = 1'b1;
        mem_we    = hold_is_sw;
        mem_addr  = hold_o_q[11:0];
        mem_wdata = hold_b_q;
      end
    end
  end

  assign ir_out      = ir_out_q;
  assign o_out       = o_out_q;
  assign d_out       = d_out_q;
  assign valid_out   = valid_out_q;
  assign mem_timeout = timeout_q;

endmodule
